cic_interp: RTL and testbench
=============================

Name: cic_interp

Overview:
- N-stage CIC interpolator. Rebuilds a high-rate sample stream from a low-rate stream.
- Pairs a comb section (y[n] = x[n] - x[n-1], low rate) with an integrator section (y[n] = x[n] + y[n-1], high rate). Zero-stuffing by R sits between them.
- Sits on the output path of the decimating filter chain. Valid/ready handshake on both sides.
- Output is gain-normalised so a DC input reproduces itself.

Parameters:
- DW, 16, input/output sample width (signed two's complement).
- N, 3, number of comb stages and number of integrator stages (1..6).
- LOG2R, 2, log2 of interpolation ratio R (R = 4 default; R is a power of two).
- IW, DW+N*LOG2R, internal register width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_data  in  DW  signed low-rate sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- out_data  out  DW  signed high-rate sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data this cycle

Behaviour:
- Reset (clk edge with reset=1) clears the following to 0:
  - all comb delay registers and the comb result register c_reg
  - all integrators, phase counter ph, busy
  - out_valid, out_data
- in_ready is 0 while reset=1.
- Definitions: accept = in_valid & in_ready; out_fire = out_valid & out_ready; issue = busy & (!out_valid | out_ready).
- in_ready = !busy | (issue & ph==R-1). This permits full-rate input: one input per R output slots.
- Comb section, on accept only:
  - s0 = in_data sign-extended to IW.
  - For stage k: sk = s(k-1) - d_k, then d_k <= s(k-1). The chain is combinational within the cycle.
  - c_reg <= sN. busy <= 1. ph <= 0.
- Integrator section, on issue only:
  - Stage input u = c_reg when ph==0, else 0 (zero-stuff).
  - Cascade in the same cycle: i1 <= i1+u; ik <= ik + (new i(k-1)).
  - out_data <= bits [DW-1+(N-1)*LOG2R : (N-1)*LOG2R] of the new iN, i.e. divide by R^(N-1), floor.
  - out_valid <= 1.
  - If ph==R-1: ph <= 0, and busy <= accept (a back-to-back input is taken the same cycle). Else ph <= ph+1.
- No issue & out_fire -> out_valid <= 0.
- No issue & !out_ready -> out_data and out_valid hold. Integrators and ph freeze.
- Latency: accept at cycle T -> first out_valid at T+2.
  - Steady state with out_ready=1 and continuous in_valid: out_valid stays 1 every cycle, in_ready pulses 1 cycle in R.
- Arithmetic: all internal adds/subtracts wrap modulo 2^IW with no saturation. The CIC property guarantees the final result is exact.
  - |out| <= max|in| for any input.
- accept and issue in the same cycle: c_reg gets the new sample, and ph==0 on the next issue uses it. The old c_reg was consumed at the ph==0 slot earlier.
- Reset mid-burst aborts the burst. No partial output follows. Filter history is lost, and the next output corresponds to a zero-history filter.

Test Plan:
- Impulse: in = 16, 0, 0, … (N=3, R=4), out_ready=1 -> out = 1, 3, 6, 10, 12, 12, 10, 6, 3, 1, then 0s. First out_valid 2 cycles after accept.
- Negative impulse: in = -16, 0, 0, … -> out = -1, -3, -6, -10, -12, -12, -10, -6, -3, -1, 0 …
- DC and throughput: in = 100 continuously, in_valid=1, out_ready=1 -> after transient, out = 100 every cycle; out_valid never drops; in_ready high exactly 1 cycle in 4.
- Backpressure: impulse 16 with out_ready low for 5 cycles at the 3rd output -> out_data holds 6 with out_valid=1; in_ready=0 during the stall; the sequence resumes 10, 12, … with no loss or duplication.
- Full-scale wrap: in alternates +32767/-32768 each input -> internal wrap is invisible; out matches the reference model bit-exactly and stays within [-32768, 32767].
- Reset mid-burst: assert reset after the 2nd output of impulse 16 -> out_valid=0 and in_ready=0 during reset. After release, in_ready=1, and a new impulse 16 reproduces 1, 3, 6, … from the start.

Source files
------------

// File: rtl/cic_interp.sv
// N-stage CIC interpolator: a low-rate comb chain, zero-stuffing by R, and a high-rate integrator chain.
// The output is divided by R^(N-1), so a DC input reproduces itself at the output.
module cic_interp #(
   parameter int unsigned DW    = 16,
   parameter int unsigned N     = 3,
   parameter int unsigned LOG2R = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   localparam int unsigned IW = DW + N * LOG2R;
   localparam int unsigned SH = (N - 1) * LOG2R;
   localparam int unsigned PW = (LOG2R > 0) ? LOG2R : 1;
   localparam logic [PW-1:0] PhLast = PW'((1 << LOG2R) - 1);

   logic [IW-1:0] d_q     [N];
   logic [IW-1:0] integ_q [N];
   logic [IW-1:0] c_q;
   logic [PW-1:0] ph_q;
   logic          busy_q;
   logic          out_valid_q;
   logic [DW-1:0] out_data_q;

   logic [IW-1:0] d_d     [N];
   logic [IW-1:0] integ_d [N];
   logic [IW-1:0] c_d;
   logic [IW-1:0] comb_acc;
   logic [IW-1:0] integ_acc;
   logic          accept;
   logic          issue;
   logic          ph_last;

   assign ph_last   = (ph_q == PhLast);
   assign issue     = busy_q & (~out_valid_q | out_ready);
   assign in_ready  = ~reset & (~busy_q | (issue & ph_last));
   assign accept    = in_valid & in_ready;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;

   // Comb chain: each stage subtracts its delayed input; the delays latch the stage inputs.
   always_comb begin
      comb_acc = IW'($signed(in_data));
      for (int k = 0; k < N; k++) begin
         d_d[k]   = comb_acc;
         comb_acc = comb_acc - d_q[k];
      end
      c_d = comb_acc;
   end

   // Integrator chain fed with c_q at phase 0 and zeros otherwise.
   always_comb begin
      integ_acc = (ph_q == '0) ? c_q : '0;
      for (int k = 0; k < N; k++) begin
         integ_acc  = integ_q[k] + integ_acc;
         integ_d[k] = integ_acc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            d_q[k]     <= '0;
            integ_q[k] <= '0;
         end
         c_q         <= '0;
         ph_q        <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (accept) begin
            for (int k = 0; k < N; k++) begin
               d_q[k] <= d_d[k];
            end
            c_q <= c_d;
         end
         if (issue) begin
            for (int k = 0; k < N; k++) begin
               integ_q[k] <= integ_d[k];
            end
            // Wrapped arithmetic is exact in these bits, so the slice is the floor division.
            out_data_q  <= integ_d[N-1][DW-1+SH:SH];
            out_valid_q <= 1'b1;
            if (ph_last) begin
               ph_q   <= '0;
               busy_q <= accept;
            end else begin
               ph_q <= ph_q + 1'b1;
            end
         end else begin
            if (accept) begin
               busy_q <= 1'b1;
               ph_q   <= '0;
            end
            if (out_ready) begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cic_interp.sv
// Self-checking bench for cic_interp: random and directed streams against a convolution model
// built from the CIC impulse response (boxcar of length R convolved N times).
module tb_cic_interp;

   localparam int DW    = 16;
   localparam int N     = 3;
   localparam int LOG2R = 2;
   localparam int R     = 1 << LOG2R;
   localparam int SH    = (N - 1) * LOG2R;
   localparam int HL    = N * (R - 1) + 1;
   localparam int BIG   = 1 << 30;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   longint        h [HL];
   int            xs [$];
   logic [DW-1:0] got [$];
   int            acc_cyc [$];
   int            first_v;
   bit            tr_ov [$];
   bit            tr_ir [$];
   bit            tr_stall [$];
   logic [DW-1:0] tr_od [$];
   int            tbl [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

   always #5 clk = ~clk;

   cic_interp #(.DW(DW), .N(N), .LOG2R(LOG2R)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   function automatic void build_h();
      longint a [HL];
      longint b [HL];
      int len = 1;
      for (int i = 0; i < HL; i++) a[i] = 0;
      a[0] = 1;
      repeat (N) begin
         for (int i = 0; i < HL; i++) b[i] = 0;
         for (int i = 0; i < len; i++)
            for (int j = 0; j < R; j++) b[i+j] += a[i];
         len += R - 1;
         a = b;
      end
      h = a;
   endfunction

   // Output n of the zero-stuffed stream filtered by h, then floor-divided by R^(N-1).
   function automatic logic [DW-1:0] ref_out(int n);
      longint y = 0;
      longint q;
      for (int m = 0; m < xs.size(); m++) begin
         int j = n - R * m;
         if (j >= 0 && j < HL) y += h[j] * longint'(xs[m]);
      end
      q = y >>> SH;
      return q[DW-1:0];
   endfunction

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cyc += 2;
      reset = 1'b0;
      xs.delete();
   endtask

   task automatic run(input int samples [$], input bit gaps, input bit rnd_ready,
                      input int stall_at, input int stall_len, input int stop_outs,
                      input int max_cyc);
      int idx = 0;
      int sc  = 0;
      int c   = 0;
      int total = R * samples.size();
      bit stall;
      got.delete(); acc_cyc.delete();
      tr_ov.delete(); tr_ir.delete(); tr_stall.delete(); tr_od.delete();
      first_v = -1;
      while (got.size() < total && got.size() < stop_outs && c < max_cyc) begin
         stall = (got.size() == stall_at) && (sc < stall_len);
         if (stall) sc++;
         in_valid  = (idx < samples.size()) && (!gaps || $urandom_range(0, 2) != 0);
         in_data   = (idx < samples.size()) ? DW'(samples[idx]) : '0;
         out_ready = !stall && (!rnd_ready || $urandom_range(0, 3) != 0);
         @(negedge clk);
         if (out_valid && first_v < 0) first_v = cyc;
         tr_ov.push_back(out_valid);
         tr_ir.push_back(in_ready);
         tr_od.push_back(out_data);
         tr_stall.push_back(stall);
         if (in_valid && in_ready) begin
            acc_cyc.push_back(cyc);
            idx++;
         end
         if (out_valid && out_ready) got.push_back(out_data);
         @(posedge clk);
         #1;
         cyc++;
         c++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in_data = 16'd5; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      @(posedge clk);
      #1;
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
      @(posedge clk);
      #1;
      cyc += 4;
      xs.delete();
   endtask

   task automatic test_impulse(input int amp);
      int s [$] = '{amp, 0, 0, 0, 0};
      do_reset();
      run(s, 1'b0, 1'b0, -1, 0, BIG, 200);
      xs = s;
      checks++;
      if (got.size() != R * s.size()) begin
         errors++; $display("FAIL impulse_%0d_count: got %0d expected %0d", amp, got.size(), R * s.size());
      end
      checks++;
      if (acc_cyc.size() == 0 || first_v - acc_cyc[0] != 2) begin
         errors++; $display("FAIL impulse_%0d_latency: got first valid %0d accept %0d expected gap 2",
                            amp, first_v, (acc_cyc.size() > 0) ? acc_cyc[0] : -1);
      end
      for (int i = 0; i < got.size(); i++) begin
         logic [DW-1:0] e;
         e = (i < 10) ? DW'(tbl[i] * amp / 16) : '0;
         checks++;
         if (got[i] !== e) begin
            errors++; $display("FAIL impulse_%0d[%0d]: got %0d expected %0d", amp, i, $signed(got[i]), $signed(e));
         end
         checks++;
         if (got[i] !== ref_out(i)) begin
            errors++; $display("FAIL impulse_%0d_model[%0d]: got %0d expected %0d", amp, i,
                               $signed(got[i]), $signed(ref_out(i)));
         end
      end
   endtask

   task automatic test_dc();
      int s [$];
      int zeros_after = 0;
      bit seen = 0;
      bit gap_bad = 0;
      for (int i = 0; i < 24; i++) s.push_back(100);
      do_reset();
      run(s, 1'b0, 1'b0, -1, 0, BIG, 400);
      xs = s;
      checks++;
      if (got.size() != R * s.size()) begin
         errors++; $display("FAIL dc_count: got %0d expected %0d", got.size(), R * s.size());
      end
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i] !== ref_out(i)) begin
            errors++; $display("FAIL dc_model[%0d]: got %0d expected %0d", i, $signed(got[i]), $signed(ref_out(i)));
         end
         if (i >= HL - 1) begin
            checks++;
            if (got[i] !== 16'd100) begin
               errors++; $display("FAIL dc_level[%0d]: got %0d expected 100", i, $signed(got[i]));
            end
         end
      end
      foreach (tr_ov[t]) begin
         if (tr_ov[t]) seen = 1;
         else if (seen) zeros_after++;
      end
      checks++;
      if (zeros_after != 0) begin
         errors++; $display("FAIL dc_valid_drop: got %0d idle cycles expected 0", zeros_after);
      end
      for (int i = 1; i < acc_cyc.size(); i++)
         if (acc_cyc[i] - acc_cyc[i-1] != R) gap_bad = 1;
      checks++;
      if (gap_bad || acc_cyc.size() != s.size()) begin
         errors++; $display("FAIL dc_in_ready_rate: got %0d accepts (irregular=%0d) expected %0d every %0d cycles",
                            acc_cyc.size(), gap_bad, s.size(), R);
      end
   endtask

   task automatic test_backpressure();
      int s [$] = '{16, 0, 0, 0, 0};
      int nst = 0;
      do_reset();
      run(s, 1'b0, 1'b0, 2, 5, BIG, 200);
      xs = s;
      checks++;
      if (got.size() != R * s.size()) begin
         errors++; $display("FAIL bp_count: got %0d expected %0d", got.size(), R * s.size());
      end
      for (int i = 0; i < got.size() && i < 10; i++) begin
         checks++;
         if (got[i] !== DW'(tbl[i])) begin
            errors++; $display("FAIL bp_seq[%0d]: got %0d expected %0d", i, $signed(got[i]), tbl[i]);
         end
      end
      foreach (tr_stall[t]) begin
         if (tr_stall[t]) begin
            nst++;
            checks++;
            if (tr_ov[t] !== 1'b1 || tr_od[t] !== 16'd6 || tr_ir[t] !== 1'b0) begin
               errors++; $display("FAIL bp_hold[%0d]: got valid %b data %0d in_ready %b expected 1 6 0",
                                  t, tr_ov[t], $signed(tr_od[t]), tr_ir[t]);
            end
         end
      end
      checks++;
      if (nst != 5) begin errors++; $display("FAIL bp_stall_len: got %0d expected 5", nst); end
   endtask

   task automatic test_stream(input string name, input int s [$], input bit gaps, input bit rnd);
      do_reset();
      run(s, gaps, rnd, -1, 0, BIG, 4000);
      xs = s;
      checks++;
      if (got.size() != R * s.size()) begin
         errors++; $display("FAIL %s_count: got %0d expected %0d", name, got.size(), R * s.size());
      end
      for (int i = 0; i < got.size(); i++) begin
         checks++;
         if (got[i] !== ref_out(i)) begin
            errors++; $display("FAIL %s[%0d]: got %0d expected %0d", name, i, $signed(got[i]), $signed(ref_out(i)));
         end
      end
   endtask

   task automatic test_wrap();
      int s [$];
      for (int i = 0; i < 32; i++) s.push_back((i % 2 == 0) ? 32767 : -32768);
      test_stream("wrap", s, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      int s [$];
      logic [DW-1:0] r;
      for (int i = 0; i < 40; i++) begin
         r = DW'($urandom);
         s.push_back(int'($signed(r)));
      end
      test_stream("random", s, 1'b1, 1'b1);
   endtask

   task automatic test_reset_midburst();
      int s [$] = '{16, 0, 0, 0, 0};
      do_reset();
      run(s, 1'b0, 1'b0, -1, 0, 2, 200);
      checks++;
      if (got.size() != 2) begin errors++; $display("FAIL midrst_pre_count: got %0d expected 2", got.size()); end
      reset = 1'b1; in_valid = 1'b1; in_data = 16'd16; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (k > 0) begin
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid[%0d]: got %b expected 0", k, out_valid); end
         end
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready[%0d]: got %b expected 0", k, in_ready); end
         @(posedge clk);
         #1;
      end
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_release: got in_ready %b valid %b expected 1 0", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
      cyc += 4;
      xs.delete();
      run(s, 1'b0, 1'b0, -1, 0, BIG, 200);
      checks++;
      if (got.size() != R * s.size()) begin
         errors++; $display("FAIL midrst_count: got %0d expected %0d", got.size(), R * s.size());
      end
      for (int i = 0; i < got.size() && i < 10; i++) begin
         checks++;
         if (got[i] !== DW'(tbl[i])) begin
            errors++; $display("FAIL midrst_seq[%0d]: got %0d expected %0d", i, $signed(got[i]), tbl[i]);
         end
      end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      build_h();
      test_reset();
      test_impulse(16);
      test_impulse(-16);
      test_dc();
      test_backpressure();
      test_wrap();
      test_random();
      test_reset_midburst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
